// File: rtl/uart_parity_engine.sv
// UART parity unit: TX parity generation from a latched word,
// RX serial parity accumulation/check with saturating error count.
module uart_parity_engine #(
  parameter int DATAWIDTH = 8,
  parameter int LEN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [DATAWIDTH-1:0] P_DATA,
  input  logic [2:0]           par_mode,
  input  logic [LEN_W-1:0]     data_len,
  output logic                 par_bit,
  output logic                 par_en,
  input  logic                 rx_start,
  input  logic                 rx_bit_valid,
  input  logic                 rx_bit,
  output logic                 chk_busy,
  output logic                 chk_done,
  output logic                 par_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  function automatic logic [DATAWIDTH-1:0] len_mask(
    input logic [LEN_W-1:0] l
  );
    logic [DATAWIDTH-1:0] m;
    for (int i = 0; i < DATAWIDTH; i++)
      m[i] = (LEN_W'(i) < l);
    return m;
  endfunction

  function automatic logic has_par(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  logic [LEN_W-1:0] len_eff;

  assign len_eff =
    (data_len == '0 || data_len > LEN_W'(DATAWIDTH))
    ? LEN_W'(DATAWIDTH) : data_len;

  // TX side
  logic [DATAWIDTH-1:0] tx_data;
  logic [2:0]           tx_mode;
  logic [LEN_W-1:0]     tx_len;
  logic                 tx_xor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
      tx_mode <= '0;
      tx_len  <= '0;
    end else if (data_valid) begin
      tx_data <= P_DATA & len_mask(len_eff);
      tx_mode <= par_mode;
      tx_len  <= len_eff;
    end
  end

  assign tx_xor = ^(tx_data & len_mask(tx_len));

  always_comb begin
    par_bit = 1'b0;
    case (tx_mode)
      3'd1:    par_bit = tx_xor;
      3'd2:    par_bit = ~tx_xor;
      3'd3:    par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  assign par_en = has_par(tx_mode);

  // RX checker
  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             done_d, err_d;
  logic             exp_bit;

  always_comb begin
    exp_bit = 1'b0;
    case (mode_q)
      3'd1:    exp_bit = acc_q;
      3'd2:    exp_bit = ~acc_q;
      3'd3:    exp_bit = 1'b1;
      default: exp_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (rx_start) begin
      state_d = DATA;
      mode_d  = par_mode;
      len_d   = len_eff;
      cnt_d   = '0;
      acc_d   = 1'b0;
    end else begin
      case (state_q)
        DATA: if (rx_bit_valid) begin
          acc_d = acc_q ^ rx_bit;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            if (has_par(mode_q)) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PARITY: if (rx_bit_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (rx_bit != exp_bit);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      chk_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      chk_done <= done_d;
      par_err  <= err_d;
    end
  end

  assign chk_busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (par_err && err_cnt != '1)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity unit for the UART datapath, replacing the fixed even/odd parity calculator. The TX side latches a parallel word and presents its parity bit for the serializer. The RX side accumulates parity serially as the deserializer samples bits, checks the received parity bit, and keeps a saturating error count. Both sides support runtime data length (1..DATAWIDTH) and five parity modes.

## Interface
- DATAWIDTH, 8, maximum data bits per frame
- LEN_W, 4, width of data_len; must satisfy 2^LEN_W > DATAWIDTH
- ERR_CNT_W, 8, width of the parity error counter
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- data_valid  input  1  TX: latch P_DATA, par_mode and data_len
- P_DATA  input  DATAWIDTH  TX parallel data, LSB is the first bit on the line
- par_mode  input  3  000 none, 001 even, 010 odd, 011 mark, 100 space; 101-111 treated as none
- data_len  input  LEN_W  data bits per frame; 0 or >DATAWIDTH treated as DATAWIDTH
- par_bit  output  1  TX parity bit for the latched word
- par_en  output  1  TX: latched mode has a parity bit (mode not none)
- rx_start  input  1  RX: start-bit detected; latches par_mode/data_len, starts a check
- rx_bit_valid  input  1  RX: rx_bit holds a sampled bit this cycle
- rx_bit  input  1  RX sampled bit value
- chk_busy  output  1  RX checker is in DATA or PARITY
- chk_done  output  1  one-cycle pulse: frame check complete
- par_err  output  1  one-cycle pulse with chk_done: parity mismatch
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  ERR_CNT_W  saturating parity error count

## Operation
- TX register: on data_valid, store P_DATA with bits at index >= effective length forced to 0, plus par_mode and effective length. Inputs are not used outside data_valid cycles.
- par_bit is combinational from the TX register:
  - even: XOR of the stored bits.
  - odd: the inverse of that XOR.
  - mark: 1.
  - space: 0.
  - none: 0.
- par_en is 1 when the stored mode is 001-100.
- RX FSM states: IDLE, DATA, PARITY.
  - IDLE: on rx_start, load the latched mode and length, clear the accumulator and the bit counter, and go to DATA. rx_bit_valid is ignored in IDLE.
  - DATA: each rx_bit_valid XORs rx_bit into the accumulator and increments the counter. When the bit that makes count == length is taken:
    - If mode is none, go to IDLE and pulse chk_done with par_err=0.
    - Otherwise go to PARITY.
  - PARITY: on the next rx_bit_valid, compare rx_bit against the expected bit. Expected is acc (even), ~acc (odd), 1 (mark) or 0 (space). Pulse chk_done, set par_err=(rx_bit!=expected), and go to IDLE.
- rx_start in DATA or PARITY aborts the current frame with no chk_done, then restarts as from IDLE in the same cycle.
- rx_start and rx_bit_valid in the same cycle: rx_start wins and the bit is dropped.
- err_cnt increments on each par_err pulse and saturates at all-ones.
- err_clr has priority over an increment in the same cycle.
- TX and RX paths are independent, and may be active in the same cycle.

## Timing
- Reset values:
  - TX register, stored mode and length all 0, so par_bit=0 and par_en=0.
  - FSM in IDLE, chk_busy=0, chk_done=0, par_err=0, err_cnt=0.
- par_bit and par_en reflect new data from the cycle after the data_valid edge (1-cycle latency).
- chk_busy is registered: high from the cycle after the rx_start edge until the cycle after the final sampling edge.
- chk_done and par_err are registered: high for exactly the one cycle after the edge that samples the parity bit (or the last data bit when mode is none).
- err_cnt updates one cycle after the par_err pulse becomes visible.
- Reset asserted mid-frame returns the FSM to IDLE immediately; no chk_done is produced.
- Changing par_mode or data_len mid-frame has no effect until the next rx_start or data_valid.

## Test plan
- TX even/odd/mark/space with data_len=8:
  - P_DATA=0xA7, even -> par_bit=1.
  - odd -> par_bit=0.
  - mark -> par_bit=1.
  - space -> par_bit=0.
  - none -> par_en=0.
- TX length masking: data_len=5, P_DATA=0xF1, even -> par_bit=0 (only 0x11 counted). data_len=0 -> treated as 8 -> par_bit=1.
- RX good frame: rx_start, 8 bits of 0x35 LSB first, mode even, parity bit 0 -> one-cycle chk_done=1, par_err=0, err_cnt stays 0.
- RX bad frames:
  - Same frame with parity bit 1 -> par_err=1, err_cnt=1.
  - Repeat 300 times with ERR_CNT_W=8 -> err_cnt saturates at 255.
  - err_clr together with par_err -> err_cnt=0.
- RX mode none with data_len=7: chk_done is asserted after the 7th bit with par_err=0. A following stray rx_bit_valid in IDLE is ignored.
- Abort and reset:
  - rx_start after 3 data bits restarts the frame; only one chk_done is seen.
  - rst asserted in PARITY -> chk_busy=0, no chk_done, err_cnt=0.
